// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - Philips I2S transmitter for mono samples duplicated into both slots
//
// Purpose:
//   Takes one mono sample per frame from the upstream FIFO and shifts it out
//   MSB first on a standard I2S link. The left and right slots carry the same
//   sample. Data lags word select by one bit clock, so each right-channel LSB
//   goes out in slot 0 of the following frame.
//
// Parameters:
//   PKT_WIDTH  sample width; a frame is 2*PKT_WIDTH bit slots (>= 2)
//   CLK_DIV    clk_i cycles per bit-clock period (even, >= 2)
//
// Ports:
//   clk_i        system clock; all logic uses its rising edge
//   reset_i      synchronous, active-high reset
//   pkt_i        signed sample from the upstream FIFO
//   pktValid_i   one-cycle strobe qualifying pkt_i
//   sampleReq_o  one-cycle pulse at each frame latch
//   bclk_o       I2S bit clock
//   ws_o         word select (0 = left, 1 = right)
//   sd_o         serial data, MSB first
//   underrun_o   one-cycle pulse: frame latched with no pending sample
//   overrun_o    one-cycle pulse: pending sample overwritten before use
//
// Build option:
//   I2S_TX_UNDERRUN_MUTE_EN  when defined, an underrun sends silence and clears
//                            the held sample; otherwise the last sample repeats.

module i2s_tx_serializer #(
    parameter int PKT_WIDTH = 16,
    parameter int CLK_DIV   = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [PKT_WIDTH-1:0] pkt_i,
    input  logic                 pktValid_i,
    output logic                 sampleReq_o,
    output logic                 bclk_o,
    output logic                 ws_o,
    output logic                 sd_o,
    output logic                 underrun_o,
    output logic                 overrun_o
);

    localparam int DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int SLOT_W = $clog2(2 * PKT_WIDTH);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF   = DIV_W'(CLK_DIV / 2);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(2 * PKT_WIDTH - 1);
    localparam logic [SLOT_W-1:0] SLOT_RIGHT = SLOT_W'(PKT_WIDTH);

    // Bit-clock divider and slot position
    logic [DIV_W-1:0]     r_div_cnt;
    logic [SLOT_W-1:0]    r_slot;

    // Serial outputs
    logic                 r_bclk;
    logic                 r_ws;
    logic                 r_sd;

    // Frame data: r_frame holds the sample for the current frame, r_shift is
    // the working copy that is shifted out one bit per slot.
    logic [PKT_WIDTH-1:0] r_frame;
    logic [PKT_WIDTH-1:0] r_shift;

    // Intake side
    logic [PKT_WIDTH-1:0] r_hold;
    logic                 r_pending;
    logic [PKT_WIDTH-1:0] r_last;

    // Status pulses
    logic                 r_sample_req;
    logic                 r_underrun;
    logic                 r_overrun;

    logic [DIV_W-1:0]     w_div_next;
    logic                 w_fall;
    logic                 w_bclk_next;
    logic [SLOT_W-1:0]    w_slot_next;
    logic                 w_latch;
    logic                 w_consume;
    logic [PKT_WIDTH-1:0] w_sample;
    logic [PKT_WIDTH-1:0] w_last_next;

    // The fall event is the wrap of the divider; bclk is derived from the
    // divider's next value so that it drops on the same edge as ws/sd change.
    assign w_fall      = (r_div_cnt == DIV_LAST);
    assign w_div_next  = w_fall ? '0 : r_div_cnt + 1'b1;
    assign w_bclk_next = (w_div_next >= DIV_HALF);

    assign w_slot_next = (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;
    assign w_latch     = w_fall && (r_slot == SLOT_LAST);
    assign w_consume   = w_latch && r_pending;

    // Sample chosen for the frame that starts at this latch
    always_comb begin
        w_sample    = r_last;
        w_last_next = r_last;
        if (r_pending) begin
            w_sample    = r_hold;
            w_last_next = r_hold;
        end else begin
`ifdef I2S_TX_UNDERRUN_MUTE_EN
            w_sample    = '0;
            w_last_next = '0;
`else
            w_sample    = r_last;
            w_last_next = r_last;
`endif
        end
    end

    // Divider and bit clock
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else begin
            r_div_cnt <= w_div_next;
            r_bclk    <= w_bclk_next;
        end
    end

    // Slot sequencing and serial data
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_slot  <= SLOT_LAST;
            r_ws    <= 1'b0;
            r_sd    <= 1'b0;
            r_frame <= '0;
            r_shift <= '0;
            r_last  <= '0;
        end else if (w_fall) begin
            r_slot <= w_slot_next;
            r_ws   <= (w_slot_next >= SLOT_RIGHT);
            if (w_latch) begin
                // Slot 0 still belongs to the old frame: its right LSB.
                r_sd    <= r_frame[0];
                r_frame <= w_sample;
                r_shift <= w_sample;
                r_last  <= w_last_next;
            end else if (w_slot_next == SLOT_RIGHT) begin
                // Last left bit goes out; reload so the right slot restarts at the MSB.
                r_sd    <= r_shift[PKT_WIDTH-1];
                r_shift <= r_frame;
            end else begin
                r_sd    <= r_shift[PKT_WIDTH-1];
                r_shift <= {r_shift[PKT_WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sample intake. A strobe on the latch cycle refills holding after the
    // latch has taken the old value, so pending stays set without an overrun.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_hold    <= '0;
            r_pending <= 1'b0;
        end else if (pktValid_i) begin
            r_hold    <= pkt_i;
            r_pending <= 1'b1;
        end else if (w_consume) begin
            r_pending <= 1'b0;
        end
    end

    // Status pulses
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_sample_req <= 1'b0;
            r_underrun   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_sample_req <= w_latch;
            r_underrun   <= w_latch && !r_pending;
            r_overrun    <= pktValid_i && r_pending && !w_consume;
        end
    end

    assign bclk_o      = r_bclk;
    assign ws_o        = r_ws;
    assign sd_o        = r_sd;
    assign sampleReq_o = r_sample_req;
    assign underrun_o  = r_underrun;
    assign overrun_o   = r_overrun;

endmodule

// File: doc/i2s_tx_serializer.md
# i2s_tx_serializer

Serializes processed mono audio samples from the DSP output path onto a standard Philips I2S link (bit clock, word select, serial data). It sits at the transmit end of the chorus chain, after the FTS CDC FIFO. It consumes one sample per frame on a valid strobe, requests the next sample at each frame boundary, and duplicates each mono sample into the left and right slots.

## Interface
Parameters:
- PKT_WIDTH, 16, sample width; frame = 2*PKT_WIDTH bit slots (32 at default)
- CLK_DIV, 4, clk_i cycles per bit-clock period; even, >= 2

Ports:
- clk_i  input  1  system clock; all logic on rising edge
- reset_i  input  1  synchronous, active-high reset
- pkt_i  input  PKT_WIDTH  signed sample from upstream FIFO
- pktValid_i  input  1  one-cycle strobe: pkt_i valid this cycle
- sampleReq_o  output  1  one-cycle pulse at frame latch; upstream may present next sample
- bclk_o  output  1  I2S bit clock
- ws_o  output  1  word select; 0 = left, 1 = right
- sd_o  output  1  serial data, MSB first
- underrun_o  output  1  one-cycle pulse: frame latched with no pending sample
- overrun_o  output  1  one-cycle pulse: pending sample overwritten before use

## Operation
- Divider counter divCnt cycles 0..CLK_DIV-1; bclk_o = (divCnt >= CLK_DIV/2), registered.
- Fall event: the cycle divCnt wraps CLK_DIV-1 -> 0. All ws_o, sd_o, and slot updates occur only on fall events.
- Slot counter slot 0..2*PKT_WIDTH-1 advances on each fall event and wraps.
- ws_o = 0 for slots 0..PKT_WIDTH-1; ws_o = 1 for slots PKT_WIDTH..2*PKT_WIDTH-1.
- sd_o by slot, giving the one-bit I2S delay:
  - slot 0: previous frame right LSB
  - slots 1..PKT_WIDTH: left bits MSB..LSB
  - slots PKT_WIDTH+1..2*PKT_WIDTH-1: right bits MSB..LSB-1
  - right LSB goes out in slot 0 of the next frame
- Intake: pktValid_i writes pkt_i to the holding register and sets pending. If pending is already set and not being consumed that cycle, pulse overrun_o; the newer sample wins.
- Frame latch happens on the fall event entering slot 0:
  - If pending: frame sample = holding; clear pending; lastSample = holding.
  - Else: frame sample = lastSample (repeat); pulse underrun_o.
  - In both cases pulse sampleReq_o.
- Simultaneous latch and pktValid_i: the latch consumes the old holding value, the new pkt_i enters holding, pending stays set, no overrun.
- Left = right = frame sample. Bits are transmitted unmodified (two's complement).

## Timing
- Reset values: bclk_o=0, ws_o=0, sd_o=0, sampleReq_o=0, underrun_o=0, overrun_o=0.
- Reset internal state: divCnt=0, slot=2*PKT_WIDTH-1, holding=0, lastSample=0, pending=0.
- First fall event occurs at clk_i cycle CLK_DIV after reset deasserts, and enters slot 0. The first frame transmits zero plus underrun unless pktValid_i arrived earlier.
- sd_o and ws_o change in the same cycle bclk_o falls. They are stable for CLK_DIV cycles and are sampled by the receiver on the bclk_o rise.
- Latency: a sample accepted before a latch appears on sd_o at the next fall event (slot 1 MSB). Worst case is one frame later.
- reset_i mid-frame: all outputs return to reset values the next cycle and the frame is abandoned; no partial completion.
- Status pulses and sampleReq_o are registered, one clk_i cycle wide.

## Configuration
- I2S_TX_UNDERRUN_MUTE_EN defined: on underrun the frame sample is 0 and lastSample is set to 0; underrun_o still pulses.
- Undefined: on underrun, lastSample is repeated (sample-and-hold).

## Test plan
- Basic frame: PKT_WIDTH=16, CLK_DIV=4, 0xA5C3 strobed before the first latch:
  - slots 1..16 = 1010010111000011
  - slots 17..31 plus next slot 0 repeat the same bits
  - ws_o low for slots 0..15, high for 16..31
  - bclk_o period 4 cycles
- Underrun, macro undefined: 0x1234 then no strobe -> second frame repeats 0x1234 on both channels; underrun_o pulses once at its latch.
- Underrun, macro defined: same stimulus -> second frame all zeros; underrun_o pulses once.
- Overrun: 0x1111 then 0x2222 within one frame -> overrun_o pulses once; next frame carries 0x2222.
- Coincident strobe: pktValid_i with 0x7FFF exactly on the latch cycle while 0x8000 is pending -> that frame sends 0x8000 and the next sends 0x7FFF; no overrun, no underrun.
- Mid-frame reset: assert reset_i at slot 20 -> next cycle all outputs are 0; first new fall event at cycle CLK_DIV after release; slot 0 transmits 0.
